// File: rtl/mem_arbiter.sv
`default_nettype none
//=============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory_controller port between a CPU and a DMA master.
//            Holds the controller enable for ACCESS_CYCLES clocks, returns read
//            data with a one-cycle ack, then forces two enable-low clocks
//            (DONE + GAP) before the next access.
//            Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise
//            fixed priority selected by CPU_PRIORITY.
// Revision : 1.0 - initial release
//=============================================================================
module mem_arbiter #(
   parameter int ACCESS_CYCLES = 3,
   parameter int CPU_PRIORITY  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ack,
   input  logic [15:0] dma_addr,
   input  logic [15:0] dma_wdata,
   input  logic        dma_rd,
   input  logic        dma_wr,
   output logic [15:0] dma_rdata,
   output logic        dma_ack,
   output logic [15:0] mc_address,
   output logic [15:0] mc_data_in,
   input  logic [15:0] mc_data_out,
   output logic        mc_read_en,
   output logic        mc_write_en,
   output logic        grant_dma,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [15:0] w_addr_nxt, w_wdata_nxt, w_cpu_rdata_nxt, w_dma_rdata_nxt;
   logic        w_rd_en_nxt, w_wr_en_nxt, w_cpu_ack_nxt, w_dma_ack_nxt;
   logic        w_grant_dma_nxt, w_busy_nxt;
   logic        w_cpu_pend, w_dma_pend, w_pick_dma, w_pick_rd;
`ifdef MEM_ARBITER_RR_EN
   logic        r_prio_dma, w_prio_dma_nxt;
`endif

   // Winner selection among pending requesters; a read wins over a write.
   always_comb begin
      w_cpu_pend = cpu_rd | cpu_wr;
      w_dma_pend = dma_rd | dma_wr;
`ifdef MEM_ARBITER_RR_EN
      w_pick_dma = w_dma_pend & (~w_cpu_pend | r_prio_dma);
`else
      w_pick_dma = w_dma_pend & (~w_cpu_pend | (CPU_PRIORITY == 0));
`endif
      w_pick_rd  = w_pick_dma ? dma_rd : cpu_rd;
   end

   // Next-state and next-output logic for the access sequencer.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_addr_nxt      = mc_address;
      w_wdata_nxt     = mc_data_in;
      w_rd_en_nxt     = mc_read_en;
      w_wr_en_nxt     = mc_write_en;
      w_cpu_ack_nxt   = 1'b0;
      w_dma_ack_nxt   = 1'b0;
      w_cpu_rdata_nxt = cpu_rdata;
      w_dma_rdata_nxt = dma_rdata;
      w_grant_dma_nxt = grant_dma;
`ifdef MEM_ARBITER_RR_EN
      w_prio_dma_nxt  = r_prio_dma;
`endif
      case (r_state)
         // GAP takes the IDLE decision on its exit edge, so back-to-back
         // windows are separated by exactly DONE + GAP. The served requester
         // has already dropped its request after seeing ack in DONE.
         ST_IDLE, ST_GAP: begin
            if (w_cpu_pend | w_dma_pend) begin
               w_grant_dma_nxt = w_pick_dma;
               w_addr_nxt      = w_pick_dma ? dma_addr  : cpu_addr;
               w_wdata_nxt     = w_pick_dma ? dma_wdata : cpu_wdata;
               w_rd_en_nxt     = w_pick_rd;
               w_wr_en_nxt     = ~w_pick_rd;
               w_cnt_nxt       = CNT_LOAD;
               w_state_nxt     = ST_ACCESS;
            end else begin
               w_state_nxt     = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (r_cnt == 4'd0) begin
               w_rd_en_nxt   = 1'b0;
               w_wr_en_nxt   = 1'b0;
               w_cpu_ack_nxt = ~grant_dma;
               w_dma_ack_nxt = grant_dma;
               // Read data is captured so it is valid alongside the ack.
               if (mc_read_en) begin
                  if (grant_dma) w_dma_rdata_nxt = mc_data_out;
                  else           w_cpu_rdata_nxt = mc_data_out;
               end
               w_state_nxt   = ST_DONE;
            end else begin
               w_cnt_nxt     = r_cnt - 4'd1;
            end
         end
         ST_DONE: begin
`ifdef MEM_ARBITER_RR_EN
            w_prio_dma_nxt = ~grant_dma;
`endif
            w_state_nxt    = ST_GAP;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // State and registered outputs; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         mc_address  <= 16'd0;
         mc_data_in  <= 16'd0;
         mc_read_en  <= 1'b0;
         mc_write_en <= 1'b0;
         cpu_ack     <= 1'b0;
         dma_ack     <= 1'b0;
         cpu_rdata   <= 16'd0;
         dma_rdata   <= 16'd0;
         grant_dma   <= 1'b0;
         busy        <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
         r_prio_dma  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         mc_address  <= w_addr_nxt;
         mc_data_in  <= w_wdata_nxt;
         mc_read_en  <= w_rd_en_nxt;
         mc_write_en <= w_wr_en_nxt;
         cpu_ack     <= w_cpu_ack_nxt;
         dma_ack     <= w_dma_ack_nxt;
         cpu_rdata   <= w_cpu_rdata_nxt;
         dma_rdata   <= w_dma_rdata_nxt;
         grant_dma   <= w_grant_dma_nxt;
         busy        <= w_busy_nxt;
`ifdef MEM_ARBITER_RR_EN
         r_prio_dma  <= w_prio_dma_nxt;
`endif
      end
   end

endmodule
`default_nettype wire
